add4_fa_core: RTL and testbench
===============================

Name: add4_fa_core

Overview:
- 4-bit unsigned adder built as a ripple chain of four 1-bit full adders.
- Produces a 4-bit sum S and a carry-out C combinationally from A and B.
- Also provides a registered copy of the 5-bit result, one clock later, for downstream synchronous logic.
- Sits at leaf level in the arithmetic datapath and is used as a basic building block by wider adders and accumulators.

Parameters:
- WIDTH, 4, operand width. The ripple chain has WIDTH full-adder stages. The block is verified at 4 only.

Ports:
- clk  input  1  single clock, rising-edge active; used only by the registered outputs.
- rst_n  input  1  asynchronous, active-low reset; clears the registered outputs.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- S  output  WIDTH  combinational sum bits, equal to (A+B)[WIDTH-1:0].
- C  output  1  combinational carry-out, equal to (A+B)[WIDTH].
- S_q  output  WIDTH  S registered on the rising edge of clk.
- C_q  output  1  C registered on the rising edge of clk.

Behaviour:
- Combinational path:
  - {C,S} = A + B, exact and unsigned, with no truncation of the carry.
  - Zero clock latency: S and C settle within the same half-cycle after A or B changes.
  - The bench samples on the falling edge after driving inputs on the rising edge.
- Ripple structure:
  - Stage i computes s[i] = A[i]^B[i]^c[i] and c[i+1] = (A[i]&B[i]) | (c[i]&(A[i]^B[i])).
  - c[0] = 0; there is no carry-in port. C = c[WIDTH].
- S and C do not depend on clk or rst_n; they stay valid during reset.
- Registered path:
  - On posedge clk with rst_n=1: S_q <= S and C_q <= C. Latency is 1 cycle.
  - rst_n=0: S_q = 0 and C_q = 0 immediately, independent of clk.
  - Reset is released synchronously to downstream logic by the system. The first capture happens on the first posedge with rst_n=1.
  - Reset asserted mid-operation clears S_q/C_q at once. Combinational outputs keep tracking the inputs.
- Boundary conditions:
  - 15+15 gives C=1, S=1110.
  - 15+1 gives C=1, S=0000 (wrap-around of S; C carries the overflow).
  - 0+0 gives C=0, S=0000.
- No X propagation for known inputs. With X on an input bit, only the dependent sum bits and higher carries may go X.

Decomposition:
- Shared package arith_pkg: localparam ADD_WIDTH=4 and typedef logic [ADD_WIDTH-1:0] nib_t for operands and sum.
- One sub-module, full_adder_bit: ports a, b, cin, s, cout. It is instantiated WIDTH times in a generate loop, with carry chained LSB to MSB.
- Output registers live in add4_fa_core as a single always_ff block with async reset.

Test Plan:
- Reset: hold rst_n=0 with A=4'b1010, B=4'b0101 -> S=1111, C=0 combinationally; S_q=0000, C_q=0. Release reset; after the next posedge S_q=1111, C_q=0.
- Full carry ripple: A=4'b1111, B=4'b0001 -> S=0000, C=1 by the next falling edge; S_q=0000, C_q=1 one cycle later.
- Max operands: A=15, B=15 -> S=1110, C=1. Zero operands: A=0, B=0 -> S=0000, C=0.
- Mid-operation reset: drive A=9, B=8 (S=0001, C=1), clock once, then pulse rst_n=0 between edges -> S_q/C_q go to 0 immediately; S/C stay 0001/1.
- Random sweep: new random A,B on each rising edge for 1000 cycles. On each falling edge check {C,S}==A+B and print CORRECT/WRONG. Check {C_q,S_q} equals the previous cycle's A+B.
- Exhaustive: all 256 (A,B) pairs -> {C,S}==A+B for each pair, zero mismatches.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic types for the leaf adder blocks.
package arith_pkg;
    localparam int ADD_WIDTH = 4;
    typedef logic [ADD_WIDTH-1:0] nib_t;
endpackage

// File: rtl/full_adder_bit.sv
// One ripple stage: sum and carry of two operand bits plus carry-in.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/add4_fa_core.sv
// Ripple-carry adder with combinational {C,S} and a registered copy.
module add4_fa_core
    import arith_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic [WIDTH-1:0] S_q,
    output logic             C_q
);
    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder_bit u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (S[i]),
            .cout (c[i+1])
        );
    end

    assign C = c[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q <= '0;
            C_q <= 1'b0;
        end else begin
            S_q <= S;
            C_q <= C;
        end
    end
endmodule

// File: tb/tb_add4_fa_core.sv
// Directed and random checks of the 4-bit ripple adder and its register.
module tb_add4_fa_core;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] S;
    logic       C;
    logic [3:0] S_q;
    logic       C_q;

    int checks   = 0;
    int failures = 0;
    int sweep_bad = 0;
    logic [4:0] sb[$];

    add4_fa_core #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .S     (S),
        .C     (C),
        .S_q   (S_q),
        .C_q   (C_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check the previous capture, drive new operands on the rising edge,
    // then check the combinational result on the falling edge.
    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input string tag);
        logic [4:0] exp;
        @(posedge clk);
        #1;
        if (sb.size() > 0)
            chk({tag, "_reg"}, {C_q, S_q}, sb.pop_front());
        A = a;
        B = b;
        exp = {1'b0, a} + {1'b0, b};
        sb.push_back(exp);
        @(negedge clk);
        chk({tag, "_comb"}, {C, S}, exp);
    endtask

    initial begin
        logic [4:0] e;
        int f0;

        rst_n = 1'b0;
        A = 4'b1010;
        B = 4'b0101;
        #12;
        chk("rst_comb", {C, S}, 5'b0_1111);
        chk("rst_reg", {C_q, S_q}, 5'b0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(5'b0_1111);

        drive(4'd15, 4'd1, "ripple");
        chk("ripple_val", {C, S}, 5'b1_0000);
        drive(4'd15, 4'd15, "max");
        chk("max_val", {C, S}, 5'b1_1110);
        drive(4'd0, 4'd0, "zero");
        chk("zero_val", {C, S}, 5'b0_0000);
        drive(4'd9, 4'd8, "nine8");

        @(posedge clk);
        #1;
        chk("nine8_reg", {C_q, S_q}, sb.pop_front());
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_reg", {C_q, S_q}, 5'b0_0000);
        chk("midrst_comb", {C, S}, 5'b1_0001);
        @(negedge clk);
        chk("midrst_hold", {C_q, S_q}, 5'b0_0000);
        rst_n = 1'b1;

        f0 = failures;
        for (int i = 0; i < 1000; i++)
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "sweep");
        @(posedge clk);
        #1;
        chk("sweep_last_reg", {C_q, S_q}, sb.pop_front());
        sweep_bad = failures - f0;
        if (sweep_bad == 0)
            $display("random sweep CORRECT");
        else
            $display("random sweep WRONG count=%0d", sweep_bad);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                A = 4'(a);
                B = 4'(b);
                e = 5'(a + b);
                #1;
                chk("exhaustive", {C, S}, e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
